// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one memory port between the fetch and data channels.
// Data has fixed priority, a refused request locks the port, and responses are routed in request order.
module mem_req_arbiter #(
    parameter int OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    localparam int PW = $clog2(OUTSTANDING);
    localparam logic [PW:0] FULL_CNT = OUTSTANDING[PW:0];
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    logic                   lock_vld_q, lock_vld_d;
    logic                   lock_own_q, lock_own_d;
    logic [OUTSTANDING-1:0] own_q, own_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW:0]            count_q, count_d;
    logic                   sel, full, push, pop, head;

    // A refused request keeps the port until accepted, so its payload stays stable.
    assign sel  = lock_vld_q ? lock_own_q : (data_req ? OWN_DATA : OWN_INST);
    assign full = count_q == FULL_CNT;

    assign mem_req   = (sel == OWN_DATA ? data_req : inst_req) & ~full;
    assign mem_wr    = sel == OWN_DATA ? data_wr    : 1'b0;
    assign mem_size  = sel == OWN_DATA ? data_size  : 2'd2;
    assign mem_addr  = sel == OWN_DATA ? data_addr  : inst_addr;
    assign mem_wstrb = sel == OWN_DATA ? data_wstrb : 4'h0;
    assign mem_wdata = sel == OWN_DATA ? data_wdata : 32'h0;

    assign push         = mem_req & mem_addr_ok;
    assign data_addr_ok = push & (sel == OWN_DATA);
    assign inst_addr_ok = push & (sel == OWN_INST);

    // A response with nothing in flight is a stray and is dropped.
    assign pop          = mem_data_ok & (count_q != '0);
    assign head         = own_q[rd_ptr_q];
    assign inst_data_ok = pop & (head == OWN_INST);
    assign data_data_ok = pop & (head == OWN_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_comb begin
        lock_vld_d = mem_req ? ~mem_addr_ok : lock_vld_q;
        lock_own_d = (mem_req & ~mem_addr_ok) ? sel : lock_own_q;
        own_d      = own_q;
        if (push) own_d[wr_ptr_q] = sel;
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_vld_q <= 1'b0;
            lock_own_q <= OWN_INST;
            own_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
            own_q      <= own_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: randomized and directed stimulus against a queue-based reference model with a response scoreboard.
module tb_mem_req_arbiter;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 1'b0, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr = '0, inst_rdata;
    logic        data_req = 1'b0, data_wr = 1'b0, data_addr_ok, data_data_ok;
    logic [1:0]  data_size = '0;
    logic [31:0] data_addr = '0, data_wdata = '0, data_rdata;
    logic [3:0]  data_wstrb = '0;
    logic        mem_req, mem_wr, mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0]  mem_wstrb;

    always #5 clk = ~clk;

    mem_req_arbiter #(.OUTSTANDING(N)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    // Reference state: in-flight owners in issue order (1=data) and the channel holding a refused request.
    bit q[$];
    bit m_lock = 1'b0, m_own = 1'b0;
    int n_vec = 0, n_err = 0;

    function automatic void chk(string nm, logic [70:0] act, logic [70:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic cyc(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                       input logic [1:0] ds, input logic [31:0] da, input logic [3:0] st,
                       input logic [31:0] dd, input bit aok, input bit dok, input logic [31:0] rd);
        bit s, req;
        inst_req = ir; inst_addr = ia;
        data_req = dr; data_wr = dw; data_size = ds; data_addr = da; data_wstrb = st; data_wdata = dd;
        mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rd;
        #2;
        s   = m_lock ? m_own : dr;
        req = (s ? dr : ir) && q.size() < N;
        chk("mem_req", 71'(mem_req), 71'(req));
        chk("payload", {mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata},
            s ? {dw, ds, da, st, dd} : {1'b0, 2'd2, ia, 4'h0, 32'h0});
        chk("addr_ok", 71'({inst_addr_ok, data_addr_ok}), 71'({req && aok && !s, req && aok && s}));
        @(posedge clk);
        if (req && aok) begin
            q.push_back(s);
            m_lock = 1'b0;
        end else if (req) begin
            m_lock = 1'b1;
            m_own  = s;
        end
        #1;
    endtask

    task automatic idle(input bit dok);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, dok, $urandom);
    endtask

    task automatic drain;
        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
        chk("drain", 71'(q.size()), 71'(0));
    endtask

    task automatic do_reset;
        inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        resetn = 1'b0;
        q.delete();
        m_lock = 1'b0;
        m_own  = 1'b0;
        #3;
        chk("reset", 71'({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 71'(0));
        @(posedge clk);
        #1;
        mem_data_ok = 0;
        resetn = 1'b1;
    endtask

    // Response scoreboard: every cycle the head owner decides which data_ok must fire.
    initial begin : monitor
        bit o, hv;
        forever begin
            @(negedge clk);
            if (resetn) begin
                hv = mem_data_ok && q.size() != 0;
                o  = 1'b0;
                if (hv) o = q.pop_front();
                chk("data_ok", 71'({inst_data_ok, data_data_ok}), 71'({hv && !o, hv && o}));
                if (hv) chk("rdata", 71'({inst_rdata, data_rdata}), 71'({mem_rdata, mem_rdata}));
            end
        end
    end

    initial begin
        do_reset();
        // both channels request together: data first, then inst
        cyc(1, 32'h1000, 1, 0, 2, 32'h2000, 0, 0, 1, 0, 0);
        cyc(1, 32'h1000, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        drain();
        // inst refused twice, data arriving mid-lock must wait
        cyc(1, 32'h1100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 32'h1100, 1, 1, 2, 32'h2100, 4'hf, 32'hdead_beef, 0, 0, 0);
        cyc(1, 32'h1100, 1, 1, 2, 32'h2100, 4'hf, 32'hdead_beef, 1, 0, 0);
        cyc(0, 0, 1, 1, 2, 32'h2100, 4'hf, 32'hdead_beef, 1, 0, 0);
        drain();
        // fill I,D,I,D then a further data request sees full
        cyc(1, 32'h1200, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 2, 32'h2200, 0, 0, 1, 0, 0);
        cyc(1, 32'h1204, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 2, 32'h2204, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 2, 32'h2208, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5000_0000 + i);
        drain();
        // accept and respond in the same cycle with two in flight
        cyc(1, 32'h1300, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0, 32'h2301, 0, 0, 1, 0, 0);
        cyc(1, 32'h1304, 0, 0, 0, 0, 0, 0, 1, 1, 32'h1234_5678);
        drain();
        // halfword store
        cyc(0, 0, 1, 1, 1, 32'h2402, 4'b0011, 32'h0000_abcd, 1, 0, 0);
        drain();
        // reset with three in flight, then a stray response
        cyc(1, 32'h1500, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 2, 32'h2500, 0, 0, 1, 0, 0);
        cyc(1, 32'h1504, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        do_reset();
        idle(1);
        cyc(1, 32'h1600, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 32'h1600, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        drain();
        repeat (600)
            cyc($urandom % 2, $urandom, $urandom % 2, $urandom % 2, $urandom % 3, $urandom,
                $urandom, $urandom, ($urandom % 4) != 0, ($urandom % 3) == 0, $urandom);
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
